counter_ctrl: RTL
=================

# counter_ctrl

Sequencing controller for the team's 20-bit up-counter datapath. It accepts a timer configuration over a valid/ready handshake and drives the counter's clear and enable inputs through a programmable prescaler. It watches the counter value and signals each expiry at a programmed limit, in one-shot or periodic mode. It sits between software-facing configuration logic and the counter instance, so the counter itself stays a plain enable/clear register.

## Interface
- WIDTH, 20, counter/limit width; must match the counter datapath
- PRESCALE_W, 8, prescaler field width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller accepts configuration (high only in IDLE)
- cfg_limit  in  WIDTH  terminal count L
- cfg_prescale  in  PRESCALE_W  prescale P; counter advances every P+1 cycles
- cfg_periodic  in  1  1 = restart after expiry, 0 = one-shot
- stop  in  1  abort current timer
- cnt_value  in  WIDTH  registered output of the counter datapath
- cnt_clr  out  1  synchronous clear to counter
- cnt_en  out  1  increment enable to counter
- busy  out  1  high in CLEAR and RUN
- expire  out  1  one-cycle registered expiry pulse
- expire_count  out  16  saturating expiry tally (see Configuration)

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: cfg_ready=1. On cfg_valid && cfg_ready, latch L, P and periodic, then go to CLEAR. cfg_valid outside IDLE is ignored.
- CLEAR: cnt_clr=1 for exactly one cycle, prescaler reset to 0, then go to RUN.
- RUN: prescaler increments and wraps at P.
  - cnt_en = (presc==P) && !hit && !stop.
  - hit = (cnt_value==L).
- On hit: expire is asserted next cycle and expire_count increments. Then go to CLEAR if periodic, else DONE.
- DONE: one cycle, then IDLE.
- stop in CLEAR or RUN: go to IDLE next cycle, no expire, no count change.
  - stop beats hit in the same cycle.
  - stop in IDLE/DONE has no effect.
- L=0: hit on the first RUN cycle; the counter is never enabled.
- P=0: cnt_en every RUN cycle until hit.
- Comparison is full-width equality. The counter never wraps under this controller because cnt_en is suppressed on hit.
- Reset values: state IDLE, cfg_ready=1, busy=0, expire=0, cnt_clr=0, cnt_en=0, expire_count=0, latched cfg=0, prescaler=0.
- Reset mid-operation returns to IDLE immediately. The counter is not cleared by this block; it has its own reset.

## Timing
- Handshake accepted at edge 0. Cycle 1 is CLEAR. Cycle 2 is RUN index 0, with cnt_value=0.
- cnt_value = k at RUN index k(P+1). hit occurs at RUN index L(P+1). expire is high on the following cycle.
- One-shot: expire coincides with DONE. cfg_ready returns 1 two cycles after the hit.
- Periodic: expire coincides with CLEAR. Period between expire pulses = L(P+1)+2 cycles.
- cnt_clr, cnt_en, cfg_ready and busy are combinational from registered state and prescaler, plus stop for cnt_en. expire is registered.

## Configuration
- Macro COUNTER_CTRL_STATUS_EN.
- Defined: expire_count is a 16-bit register that increments on each expire, saturates at 0xFFFF, and clears only on rst.
- Undefined: expire_count is tied to 0 and no register is inferred. All other behaviour is identical.

## Structure
- Package counter_ctrl_pkg: state enum (IDLE, CLEAR, RUN, DONE), default WIDTH=20, PRESCALE_W=8, expire_count width 16.
- One sub-module, counter_prescaler, which provides:
  - mod-(P+1) counter with sync clear;
  - tick output, high when value==P.

## Test plan
- Reset then idle: rst high 2 cycles → all outputs at reset values, cfg_ready=1, cnt_clr and cnt_en never pulse.
- One-shot, L=5, P=0, with the 20-bit counter attached:
  - cnt_clr at cycle 1;
  - expire exactly at cycle 8;
  - counter holds 5;
  - cfg_ready=1 at cycle 9.
- Periodic, L=3, P=2: expire pulses every 11 cycles for 4 periods; expire_count=4 with COUNTER_CTRL_STATUS_EN, 0 without.
- Stop on the hit cycle, L=4, P=0: stop asserted when cnt_value==4 → no expire, IDLE next cycle, expire_count unchanged.
- L=0, P=7: expire on the cycle after the first RUN cycle; cnt_en never asserted.
- Async rst asserted mid-RUN, between clock edges → state IDLE and busy=0 immediately. A new config (L=2, P=0) afterwards runs normally, with expire at cycle 5 after the handshake.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter sequencing controller.
package counter_ctrl_pkg;

   localparam int unsigned DefWidth     = 20;
   localparam int unsigned DefPrescaleW = 8;
   localparam int unsigned ExpCntW      = 16;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Mod-(limit+1) prescaler with synchronous clear; tick flags the terminal value.
module counter_prescaler
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned PRESCALE_W = DefPrescaleW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] limit,
   output logic [PRESCALE_W-1:0] value,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] value_q, value_d;

   assign tick  = (value_q == limit);
   assign value = value_q;

   // Next value: clear wins, otherwise count and wrap at the terminal value.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (en) begin
         value_d = tick ? '0 : value_q + 1'b1;
      end
   end

   // Prescaler state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the up-counter datapath: config handshake, prescaled
// enable, limit detection and expiry signalling. Optional expiry tally is enabled
// by defining COUNTER_CTRL_STATUS_EN.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned PRESCALE_W = DefPrescaleW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [WIDTH-1:0]      cfg_limit,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic                  cfg_periodic,
   input  logic                  stop,
   input  logic [WIDTH-1:0]      cnt_value,
   output logic                  cnt_clr,
   output logic                  cnt_en,
   output logic                  busy,
   output logic                  expire,
   output logic [ExpCntW-1:0]    expire_count
);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      limit_q;
   logic [PRESCALE_W-1:0] presc_q;
   logic                  periodic_q;
   logic                  expire_q, expire_d;
   logic                  accept;
   logic                  hit;
   logic                  tick;
   logic [PRESCALE_W-1:0] presc_value;

   assign accept = (state_q == StIdle) && cfg_valid;
   assign hit    = (cnt_value == limit_q);
   assign expire = expire_q;

   // Prescaler runs only in RUN and sits at zero everywhere else.
   counter_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_q != StRun),
      .en    (state_q == StRun),
      .limit (presc_q),
      .value (presc_value),
      .tick  (tick)
   );

   // Next-state and combinational outputs; stop takes priority over hit.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      expire_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_d = StClear;
         end
         StClear: begin
            busy    = 1'b1;
            cnt_clr = 1'b1;
            state_d = stop ? StIdle : StRun;
         end
         StRun: begin
            busy   = 1'b1;
            cnt_en = tick && !hit && !stop;
            if (stop) begin
               state_d = StIdle;
            end else if (hit) begin
               expire_d = 1'b1;
               state_d  = periodic_q ? StClear : StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, latched configuration and registered expiry pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         limit_q    <= '0;
         presc_q    <= '0;
         periodic_q <= 1'b0;
         expire_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         expire_q <= expire_d;
         if (accept) begin
            limit_q    <= cfg_limit;
            presc_q    <= cfg_prescale;
            periodic_q <= cfg_periodic;
         end
      end
   end

`ifdef COUNTER_CTRL_STATUS_EN
   logic [ExpCntW-1:0] exp_cnt_q;

   // Saturating expiry tally; advances on the same edge that raises expire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_cnt_q <= '0;
      end else if (expire_d && (exp_cnt_q != '1)) begin
         exp_cnt_q <= exp_cnt_q + 1'b1;
      end
   end

   assign expire_count = exp_cnt_q;
`else
   assign expire_count = '0;
`endif

   // presc_value is observable for debug only.
   logic unused_presc;
   assign unused_presc = ^presc_value;

endmodule
